// File: rtl/alu24_seq_unit.sv
// Handshaked 24-bit ALU responder: single-cycle logic/arith ops, optional iterative
// shift-add MUL compiled in when ALU24_MUL_EN is defined (op 110 otherwise reports err).
module alu24_seq_unit #(
  parameter int WIDTH      = 24,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_ainvert,
  input  logic             req_binvert,
  input  logic [2:0]       req_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_overflow,
  output logic             resp_cout,
  output logic             resp_err
);

  if (MUL_CYCLES != WIDTH) begin : g_bad_cfg
    $error("MUL_CYCLES must equal WIDTH");
  end

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_LOAD, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, cout_q, cout_d, err_q, err_d;
  logic             resp_valid_q, resp_valid_d;

`ifdef ALU24_MUL_EN
  localparam int CNT_W = $clog2(MUL_CYCLES + 1);
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sum;
  logic             add_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf, alu_cout, alu_err;

  assign sum_ext = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
  assign sum     = sum_ext[WIDTH-1:0];
  assign add_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);

  // Single-cycle datapath on the captured (already inverted) operands
  always_comb begin
    alu_res  = '0;
    alu_ovf  = 1'b0;
    alu_cout = 1'b0;
    alu_err  = 1'b0;
    case (op_q)
      3'b000: alu_res = a_q & b_q;
      3'b001: alu_res = a_q | b_q;
      3'b010: begin
        alu_res  = sum;
        alu_ovf  = add_ovf;
        alu_cout = sum_ext[WIDTH];
      end
      3'b011: begin
        alu_res  = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
        alu_ovf  = add_ovf;
        alu_cout = sum_ext[WIDTH];
      end
      3'b100: alu_res = a_q ^ b_q;
      3'b101: alu_res = ~(a_q | b_q);
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    cin_d        = cin_q;
    op_d         = op_q;
    result_d     = result_q;
    zero_d       = zero_q;
    ovf_d        = ovf_q;
    cout_d       = cout_q;
    err_d        = err_q;
    resp_valid_d = resp_valid_q;
`ifdef ALU24_MUL_EN
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    cnt_d        = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          a_d     = req_ainvert ? ~req_a : req_a;
          b_d     = req_binvert ? ~req_b : req_b;
          cin_d   = req_binvert;
          op_d    = req_op;
          state_d = S_EXEC;
`ifdef ALU24_MUL_EN
          acc_d   = '0;
          mcand_d = {{WIDTH{1'b0}}, a_d};
          cnt_d   = '0;
          if (req_op == 3'b110) state_d = S_MUL;
`endif
        end
      end
      S_EXEC: begin
        result_d = alu_res;
        zero_d   = (alu_res == '0);
        ovf_d    = alu_ovf;
        cout_d   = alu_cout;
        err_d    = alu_err;
        state_d  = S_LOAD;
      end
`ifdef ALU24_MUL_EN
      // b_q doubles as the multiplier shift register, LSB consumed first
      S_MUL: begin
        acc_d   = b_q[0] ? acc_q + mcand_q : acc_q;
        mcand_d = mcand_q << 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
          result_d = acc_d[WIDTH-1:0];
          zero_d   = (acc_d[WIDTH-1:0] == '0);
          ovf_d    = |acc_d[2*WIDTH-1:WIDTH];
          cout_d   = 1'b0;
          err_d    = 1'b0;
          state_d  = S_LOAD;
        end
      end
`endif
      S_LOAD: begin
        resp_valid_d = 1'b1;
        state_d      = S_DONE;
      end
      S_DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      cin_q        <= 1'b0;
      op_q         <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      ovf_q        <= 1'b0;
      cout_q       <= 1'b0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
`ifdef ALU24_MUL_EN
      acc_q        <= '0;
      mcand_q      <= '0;
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cin_q        <= cin_d;
      op_q         <= op_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      ovf_q        <= ovf_d;
      cout_q       <= cout_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
`ifdef ALU24_MUL_EN
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign resp_valid    = resp_valid_q;
  assign resp_result   = result_q;
  assign resp_zero     = zero_q;
  assign resp_overflow = ovf_q;
  assign resp_cout     = cout_q;
  assign resp_err      = err_q;

endmodule

// File: tb/tb_alu24_seq_unit.sv
// Bench for alu24_seq_unit: directed and random ops checked against an arithmetic model.
module tb_alu24_seq_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_a = '0;
  logic [23:0] req_b = '0;
  logic        req_ainvert = 1'b0;
  logic        req_binvert = 1'b0;
  logic [2:0]  req_op = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [23:0] resp_result;
  logic        resp_zero, resp_overflow, resp_cout, resp_err;

  int nchk = 0;
  int npass = 0;

  always #5 clk = ~clk;

  alu24_seq_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .req_ainvert(req_ainvert), .req_binvert(req_binvert), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .resp_overflow(resp_overflow), .resp_cout(resp_cout), .resp_err(resp_err)
  );

  typedef struct packed {
    logic [23:0] res;
    logic        z;
    logic        ov;
    logic        co;
    logic        er;
  } exp_t;

  // Reference: signed/unsigned arithmetic on 64-bit integers
  function automatic exp_t model(input logic [23:0] a, input logic [23:0] b,
                                 input logic ai, input logic bi, input logic [2:0] op);
    logic [23:0] ea, eb;
    longint ua, ub, sa, sb, u, ss, p;
    exp_t e;
    ea = ai ? ~a : a;
    eb = bi ? ~b : b;
    ua = longint'(ea);
    ub = longint'(eb);
    sa = (ua >= 64'sd8388608) ? ua - 64'sd16777216 : ua;
    sb = (ub >= 64'sd8388608) ? ub - 64'sd16777216 : ub;
    u  = ua + ub + longint'(bi);
    ss = sa + sb + longint'(bi);
    p  = ua * ub;
    e  = '0;
    case (op)
      3'd0: e.res = ea & eb;
      3'd1: e.res = ea | eb;
      3'd2: begin
        e.res = u[23:0];
        e.co  = (u >= 64'sd16777216);
        e.ov  = (ss > 64'sd8388607) || (ss < -64'sd8388608);
      end
      3'd3: begin
        e.res = (ss < 0) ? 24'd1 : 24'd0;
        e.co  = (u >= 64'sd16777216);
        e.ov  = (ss > 64'sd8388607) || (ss < -64'sd8388608);
      end
      3'd4: e.res = ea ^ eb;
      3'd5: e.res = ~(ea | eb);
`ifdef ALU24_MUL_EN
      3'd6: begin
        e.res = p[23:0];
        e.ov  = (p >= 64'sd16777216);
      end
`endif
      default: e.er = 1'b1;
    endcase
    e.z = (e.res == 24'd0);
    return e;
  endfunction

  function automatic int model_lat(input logic [2:0] op);
`ifdef ALU24_MUL_EN
    return (op == 3'd6) ? 25 : 2;
`else
    return (op == 3'd6) ? 2 : 2;
`endif
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_op(input logic [23:0] a, input logic [23:0] b, input logic ai,
                       input logic bi, input logic [2:0] op, input int hold);
    exp_t e;
    int   lat;
    e = model(a, b, ai, bi, op);
    @(negedge clk);
    check("req_ready_idle", 48'(req_ready), 48'd1);
    req_valid = 1'b1; req_a = a; req_b = b;
    req_ainvert = ai; req_binvert = bi; req_op = op;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = $urandom; req_b = $urandom; req_op = 3'($urandom);
    req_ainvert = 1'($urandom); req_binvert = 1'($urandom);
    check("req_ready_busy", 48'(req_ready), 48'd0);
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 48'(lat), 48'(model_lat(op)));
    check("result", 48'(resp_result), 48'(e.res));
    check("zero", 48'(resp_zero), 48'(e.z));
    check("overflow", 48'(resp_overflow), 48'(e.ov));
    check("cout", 48'(resp_cout), 48'(e.co));
    check("err", 48'(resp_err), 48'(e.er));
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      @(posedge clk); #1;
      check("hold_valid", 48'(resp_valid), 48'd1);
      check("hold_result", 48'(resp_result), 48'(e.res));
      check("hold_ready", 48'(req_ready), 48'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid = 1'b0;
    check("handoff_valid", 48'(resp_valid), 48'd0);
    check("handoff_ready", 48'(req_ready), 48'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 48'(req_ready), 48'd1);
    check("rst_valid", 48'(resp_valid), 48'd0);
    check("rst_result", 48'(resp_result), 48'd0);
    check("rst_flags", 48'({resp_zero, resp_overflow, resp_cout, resp_err}), 48'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(24'd0, 24'd1, 1'b0, 1'b0, 3'b100, 0);
    do_op(24'd5, 24'd5, 1'b0, 1'b1, 3'b010, 0);
    do_op(24'h7FFFFF, 24'd1, 1'b0, 1'b0, 3'b010, 0);
    do_op(24'd3, 24'd7, 1'b0, 1'b1, 3'b011, 0);
    do_op(24'd7, 24'd3, 1'b0, 1'b1, 3'b011, 0);
    do_op(24'd1000, 24'd1000, 1'b0, 1'b0, 3'b110, 0);
    do_op(24'h001000, 24'h001000, 1'b0, 1'b0, 3'b110, 0);
    do_op(24'h123456, 24'h00FF00, 1'b0, 1'b0, 3'b111, 0);
    do_op(24'hA5A5A5, 24'h0F0F0F, 1'b1, 1'b0, 3'b101, 5);

    for (int i = 0; i < 24; i++) begin
      do_op(24'($urandom), 24'($urandom), 1'($urandom), 1'($urandom),
            3'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
    end

    do_op(24'd0, 24'd1, 1'b0, 1'b0, 3'b100, 0);
    @(negedge clk);
    req_valid = 1'b1; req_a = 24'd1000; req_b = 24'd1000;
    req_ainvert = 1'b0; req_binvert = 1'b0; req_op = 3'b110;
    @(posedge clk); #1;
    req_valid = 1'b0;
`ifdef ALU24_MUL_EN
    repeat (9) @(posedge clk);
`endif
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_valid", 48'(resp_valid), 48'd0);
    check("midrst_ready", 48'(req_ready), 48'd1);
    check("midrst_result", 48'(resp_result), 48'd0);
    check("midrst_flags", 48'({resp_zero, resp_overflow, resp_cout, resp_err}), 48'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(24'h00F0F0, 24'h0F0F00, 1'b0, 1'b0, 3'b100, 1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
